// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between writeback and the MDU.
// One-entry MDU holding buffer with an anti-starvation forced grant.
module wb_port_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_wb_i,
  input  logic        reg_write_wb_i,
  input  logic [4:0]  rd_wb_i,
  input  logic [31:0] result_wb_i,
  input  logic        mdu_valid_i,
  input  logic [4:0]  mdu_rd_i,
  input  logic [31:0] mdu_result_i,
  output logic        mdu_ready_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_wdata_o,
  output logic        stall_wb_o,
  output logic        pend_valid_o,
  output logic [4:0]  pend_rd_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAXW = CW'(MAX_WAIT);

  typedef enum logic {
    EMPTY,
    HELD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [4:0]    buf_rd_q, buf_rd_d;
  logic [31:0]   buf_data_q, buf_data_d;

  logic held, wb_req, forced;
  logic mdu_grant, wb_grant, capture;

  assign held      = (state_q == HELD);
  assign wb_req    = valid_wb_i & reg_write_wb_i
                   & (rd_wb_i != 5'd0);
  assign forced    = held & wb_req & (wait_cnt_q == MAXW);
  assign mdu_grant = held & (~wb_req | forced);
  assign wb_grant  = wb_req & ~mdu_grant;
  assign capture   = mdu_valid_i & (~held | mdu_grant);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    if (capture && mdu_rd_i != 5'd0) begin
      state_d    = HELD;
      wait_cnt_d = '0;
      buf_rd_d   = mdu_rd_i;
      buf_data_d = mdu_result_i;
    end else if (mdu_grant) begin
      state_d    = EMPTY;
      wait_cnt_d = '0;
    end else if (held && wb_req) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= EMPTY;
      wait_cnt_q <= '0;
      buf_rd_q   <= '0;
      buf_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
    end
  end

  // All outputs are forced low while reset is asserted.
  always_comb begin
    mdu_ready_o  = 1'b0;
    rf_we_o      = 1'b0;
    rf_rd_o      = 5'd0;
    rf_wdata_o   = 32'd0;
    stall_wb_o   = 1'b0;
    pend_valid_o = 1'b0;
    pend_rd_o    = 5'd0;
    if (!reset_i) begin
      mdu_ready_o  = ~held | mdu_grant;
      stall_wb_o   = forced;
      pend_valid_o = held;
      pend_rd_o    = held ? buf_rd_q : 5'd0;
      if (mdu_grant) begin
        rf_we_o    = 1'b1;
        rf_rd_o    = buf_rd_q;
        rf_wdata_o = buf_data_q;
      end else if (wb_grant) begin
        rf_we_o    = 1'b1;
        rf_rd_o    = rd_wb_i;
        rf_wdata_o = result_wb_i;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: per-cycle expected outputs
// are queued by the stimulus and checked by an independent monitor.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        valid_wb_i = 1'b0;
  logic        reg_write_wb_i = 1'b0;
  logic [4:0]  rd_wb_i = '0;
  logic [31:0] result_wb_i = '0;
  logic        mdu_valid_i = 1'b0;
  logic [4:0]  mdu_rd_i = '0;
  logic [31:0] mdu_result_i = '0;
  logic        mdu_ready_o, rf_we_o, stall_wb_o, pend_valid_o;
  logic [4:0]  rf_rd_o, pend_rd_o;
  logic [31:0] rf_wdata_o;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        stall;
    logic        ready;
    logic        pv;
    logic [4:0]  prd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;

  wb_port_arbiter #(.MAX_WAIT(4)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .valid_wb_i     (valid_wb_i),
    .reg_write_wb_i (reg_write_wb_i),
    .rd_wb_i        (rd_wb_i),
    .result_wb_i    (result_wb_i),
    .mdu_valid_i    (mdu_valid_i),
    .mdu_rd_i       (mdu_rd_i),
    .mdu_result_i   (mdu_result_i),
    .mdu_ready_o    (mdu_ready_o),
    .rf_we_o        (rf_we_o),
    .rf_rd_o        (rf_rd_o),
    .rf_wdata_o     (rf_wdata_o),
    .stall_wb_o     (stall_wb_o),
    .pend_valid_o   (pend_valid_o),
    .pend_rd_o      (pend_rd_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e, a;
      e = exp_q.pop_front();
      a = '{we: rf_we_o, rd: rf_rd_o, data: rf_wdata_o,
            stall: stall_wb_o, ready: mdu_ready_o,
            pv: pend_valid_o, prd: pend_rd_o};
      popped++;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle%0d: got we=%b rd=%0d data=%h stall=%b rdy=%b pv=%b prd=%0d, want we=%b rd=%0d data=%h stall=%b rdy=%b pv=%b prd=%0d",
                 popped, a.we, a.rd, a.data, a.stall, a.ready,
                 a.pv, a.prd, e.we, e.rd, e.data, e.stall,
                 e.ready, e.pv, e.prd);
      end
    end
  end

  // rst, wb(valid,regwrite,rd,data), mdu(valid,rd,data), expected outputs
  task automatic cyc(
    input logic        rst,
    input logic        vwb, rwe,
    input logic [4:0]  rdwb,
    input logic [31:0] dwb,
    input logic        mv,
    input logic [4:0]  mrd,
    input logic [31:0] mdat,
    input logic        e_we,
    input logic [4:0]  e_rd,
    input logic [31:0] e_dat,
    input logic        e_stall, e_rdy, e_pv,
    input logic [4:0]  e_prd
  );
    exp_t e;
    reset_i        = rst;
    valid_wb_i     = vwb;
    reg_write_wb_i = rwe;
    rd_wb_i        = rdwb;
    result_wb_i    = dwb;
    mdu_valid_i    = mv;
    mdu_rd_i       = mrd;
    mdu_result_i   = mdat;
    e = '{we: e_we, rd: e_rd, data: e_dat, stall: e_stall,
          ready: e_rdy, pv: e_pv, prd: e_prd};
    exp_q.push_back(e);
    pushed++;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] D9 = 32'h0000_0099;

  initial begin
    @(posedge clk);
    #1;
    // reset: all outputs low even with an MDU result offered
    cyc(1, 0,0,0,0,   1,5,32'h5,    0,0,0,0,0,0,0);
    cyc(1, 1,1,9,D9,  0,0,0,        0,0,0,0,0,0,0);
    // idle capture then write on the next cycle
    cyc(0, 0,0,0,0,   1,7,32'hDEADBEEF, 0,0,0,0,1,0,0);
    cyc(0, 0,0,0,0,   0,0,0, 1,7,32'hDEADBEEF,0,1,1,7);
    cyc(0, 0,0,0,0,   0,0,0, 0,0,0,0,1,0,0);
    // starvation: 4 writeback grants then a forced MDU grant
    cyc(0, 0,0,0,0,   1,3,32'h33, 0,0,0,0,1,0,0);
    for (int i = 0; i < 4; i++)
      cyc(0, 1,1,9,D9, 0,0,0, 1,9,D9,0,0,1,3);
    cyc(0, 1,1,9,D9,  0,0,0, 1,3,32'h33,1,1,1,3);
    cyc(0, 1,1,9,D9,  0,0,0, 1,9,D9,0,1,0,0);
    cyc(0, 0,0,0,0,   0,0,0, 0,0,0,0,1,0,0);
    // drain and capture on the same gap cycle
    cyc(0, 0,0,0,0,   1,4,32'h44, 0,0,0,0,1,0,0);
    cyc(0, 0,0,0,0,   1,12,32'hCC, 1,4,32'h44,0,1,1,4);
    cyc(0, 1,1,10,32'hAA, 0,0,0, 1,10,32'hAA,0,0,1,12);
    cyc(0, 0,0,0,0,   0,0,0, 1,12,32'hCC,0,1,1,12);
    cyc(0, 0,0,0,0,   0,0,0, 0,0,0,0,1,0,0);
    // rd=0 MDU result dropped; x0 writeback is not a request
    cyc(0, 0,0,0,0,   1,0,32'h55, 0,0,0,0,1,0,0);
    cyc(0, 0,0,0,0,   0,0,0, 0,0,0,0,1,0,0);
    cyc(0, 1,1,0,32'h77, 1,6,32'h66, 0,0,0,0,1,0,0);
    cyc(0, 1,1,0,32'h77, 0,0,0, 1,6,32'h66,0,1,1,6);
    cyc(0, 0,0,0,0,   0,0,0, 0,0,0,0,1,0,0);
    // mdu_valid held while HELD: second result waits, not lost
    cyc(0, 1,1,9,D9,  1,8,32'h88, 1,9,D9,0,1,0,0);
    for (int i = 0; i < 4; i++)
      cyc(0, 1,1,9,D9, 1,11,32'hBB, 1,9,D9,0,0,1,8);
    cyc(0, 1,1,9,D9,  1,11,32'hBB, 1,8,32'h88,1,1,1,8);
    cyc(0, 1,1,9,D9,  0,0,0, 1,9,D9,0,0,1,11);
    cyc(0, 0,0,0,0,   0,0,0, 1,11,32'hBB,0,1,1,11);
    cyc(0, 0,0,0,0,   0,0,0, 0,0,0,0,1,0,0);
    // reset mid-HELD discards the rd=5 entry
    cyc(0, 1,1,9,D9,  1,5,32'h5555, 1,9,D9,0,1,0,0);
    cyc(1, 1,1,9,D9,  0,0,0, 0,0,0,0,0,0,0);
    cyc(0, 0,0,0,0,   0,0,0, 0,0,0,0,1,0,0);
    cyc(0, 0,0,0,0,   0,0,0, 0,0,0,0,1,0,0);
    cyc(0, 1,1,9,D9,  0,0,0, 1,9,D9,0,1,0,0);
    cyc(0, 0,0,0,0,   0,0,0, 0,0,0,0,1,0,0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge clk);
    checks++;
    if (popped != pushed) begin
      errors++;
      $display("FAIL drain: popped %0d, want %0d",
               popped, pushed);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
